load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: XLEN, 32, data and address width.
REQ-002 Parameter: TIMEOUT, 16, maximum WAIT cycles before abort (2..255).
REQ-003 Port: clk  in  1  rising-edge clock.
REQ-004 Port: rst_n  in  1  asynchronous active-low reset.
REQ-005 Port: req_valid  in  1  execute stage presents a memory access.
REQ-006 Port: req_ready  out  1  unit accepts request this cycle.
REQ-007 Port: req_we  in  1  1 = store, 0 = load.
REQ-008 Port: req_funct3  in  3  RV32I size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 Port: req_addr  in  XLEN  byte address (ALU output).
REQ-010 Port: req_wdata  in  XLEN  store data (rs2), LSB-aligned.
REQ-011 Port: rsp_valid  out  1  one-cycle pulse: access complete.
REQ-012 Port: rsp_rdata  out  XLEN  extended load data (0 for stores).
REQ-013 Port: rsp_err  out  1  valid with rsp_valid: misalign, bad funct3 or timeout.
REQ-014 Port: mem_en  out  1  memory request strobe.
REQ-015 Port: mem_we  out  1  memory write enable.
REQ-016 Port: mem_wstrb  out  4  byte-lane enables.
REQ-017 Port: mem_addr  out  XLEN  word-aligned address (low 2 bits 0).
REQ-018 Port: mem_wdata  out  XLEN  lane-replicated store data.
REQ-019 Port: mem_rdata  in  XLEN  word read data, valid with mem_ack.
REQ-020 Port: mem_ack  in  1  memory completion, sampled only in WAIT.

Function
REQ-021 FSM states IDLE, REQ, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-022 IDLE: req_valid high -> capture all req_* fields, go REQ; otherwise stay.
REQ-023 REQ: mem_en = 1 for exactly one cycle with captured address, lanes and data, -> WAIT.
REQ-024 WAIT: mem_ack -> latch mem_rdata, -> RESP; 8-bit counter increments per WAIT cycle; reaching TIMEOUT -> rsp_err = 1, -> RESP.
REQ-025 RESP: rsp_valid = 1 for one cycle, -> IDLE; minimum accept-to-rsp_valid latency 3 cycles with ack in first WAIT cycle.
REQ-026 Lanes: B 4'b0001<<addr[1:0]; H 4'b0011<<addr[1:0]; W 4'b1111; mem_wdata = byte replicated x4 for B, half x2 for H.
REQ-027 Load extract: select byte/half by addr[1:0]; B/H sign-extend bit 7/15; BU/HU zero-extend.
REQ-028 Invalid funct3 (011, 110, 111): no memory access, REQ -> RESP, rsp_err = 1, rsp_rdata = 0.
REQ-029 mem_ack outside WAIT ignored; ack arriving in same cycle as timeout counts as success.
REQ-030 mem_en, mem_we, mem_wstrb zero outside REQ; rsp_rdata, rsp_err zero outside RESP.

Reset
REQ-031 rst_n low asynchronously forces IDLE, counter 0, all outputs 0 except req_ready = 1 once FSM is IDLE.
REQ-032 Reset mid-operation abandons the access; no rsp_valid is generated for it.

Configuration
REQ-033 LSU_MISALIGN_TRAP_EN defined: H with addr[0]=1 or W with addr[1:0]!=0 skips memory, REQ -> RESP with rsp_err = 1.
REQ-034 LSU_MISALIGN_TRAP_EN undefined: misaligned offset bits are cleared (H: addr[0]; W: addr[1:0]) and the access proceeds normally.

Structure
REQ-035 Package lsu_pkg holds funct3 size constants, FSM state enum and lane-mask helper.
REQ-036 Sub-module lsu_extend: combinational load extraction and sign/zero extension.

Verification
REQ-037 SB addr 0x103, wdata 0x000000AB -> mem_wstrb 4'b1000, mem_wdata 0xABABABAB, mem_addr 0x100.
REQ-038 LB addr 0x102, mem_rdata 0x00800000 -> rsp_rdata 0xFFFFFF80; LBU same -> 0x00000080.
REQ-039 LW addr 0x101 with macro -> rsp_err 1, mem_en never asserted; without macro -> access at 0x100, rsp_err 0.
REQ-040 mem_ack withheld, TIMEOUT 16 -> rsp_valid with rsp_err 1 exactly 16 WAIT cycles after REQ.
REQ-041 rst_n low during WAIT -> next cycle IDLE, req_ready 1, no rsp_valid; following LW completes normally.
REQ-042 funct3 111 -> rsp_err 1, rsp_rdata 0, mem_en 0 throughout.

Source files
------------

// File: rtl/lsu_pkg.sv
// Load/store unit shared definitions: funct3 size codes, FSM states,
// funct3 classification and byte-lane mask helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } lsu_state_t;

    function automatic logic f3_valid(input logic [2:0] f3);
        return (f3 == F3_B)  || (f3 == F3_H)  ||
               (f3 == F3_W)  || (f3 == F3_BU) ||
               (f3 == F3_HU);
    endfunction

    // f3[1:0] is the size code: 00 byte, 01 half, 10 word
    function automatic logic is_half(input logic [2:0] f3);
        return f3[1:0] == 2'b01;
    endfunction

    function automatic logic is_word(input logic [2:0] f3);
        return f3[1:0] == 2'b10;
    endfunction

    function automatic logic [3:0] lane_mask(
        input logic [2:0] f3,
        input logic [1:0] off
    );
        logic [3:0] m;
        unique case (1'b1)
            is_half(f3): m = 4'b0011 << off;
            is_word(f3): m = 4'b1111;
            default:     m = 4'b0001 << off;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Load data extraction: selects byte/half by offset, sign/zero extends.
// Ports: funct3, off (byte offset), word (memory word) -> data.
module lsu_extend
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = 8'h00;
        unique case (off)
            2'd0: b = word[7:0];
            2'd1: b = word[15:8];
            2'd2: b = word[23:16];
            2'd3: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        data = '0;
        unique case (funct3)
            F3_B:  data = {{(XLEN-8){b[7]}}, b};
            F3_BU: data = {{(XLEN-8){1'b0}}, b};
            F3_H:  data = {{(XLEN-16){h[15]}}, h};
            F3_HU: data = {{(XLEN-16){1'b0}}, h};
            F3_W:  data = word;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: IDLE/REQ/WAIT/RESP handshake to a word memory.
// Ports: req_* from execute, rsp_* back, mem_* to memory.
// Build option LSU_MISALIGN_TRAP_EN: misaligned H/W return an error
// instead of being silently aligned.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            mem_en,
    output logic            mem_we,
    output logic [3:0]      mem_wstrb,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack
);

    localparam logic [7:0] TO = 8'(TIMEOUT);

    lsu_state_t      state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            we_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;

    logic [1:0]      off;
    logic            misalign;
    logic            skip;
    logic [XLEN-1:0] wdata_rep;
    logic [XLEN-1:0] ext_data;

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        off = addr_q[1:0];
        misalign = (is_half(f3_q) && addr_q[0]) ||
                   (is_word(f3_q) && (addr_q[1:0] != 2'b00));
    end
`else
    // Misaligned offset bits are dropped so the access stays in one word
    always_comb begin
        misalign = 1'b0;
        off = addr_q[1:0];
        if (is_half(f3_q))
            off = {addr_q[1], 1'b0};
        else if (is_word(f3_q))
            off = 2'b00;
    end
`endif

    assign skip = !f3_valid(f3_q) || misalign;

    always_comb begin
        wdata_rep = wdata_q;
        unique case (1'b1)
            is_half(f3_q): wdata_rep = XLEN'({2{wdata_q[15:0]}});
            is_word(f3_q): wdata_rep = wdata_q;
            default:       wdata_rep = XLEN'({4{wdata_q[7:0]}});
        endcase
    end

    lsu_extend #(.XLEN(XLEN)) u_extend (
        .funct3 (f3_q),
        .off    (off),
        .word   (mem_rdata),
        .data   (ext_data)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_wstrb = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_d = S_REQ;
            end
            S_REQ: begin
                rdata_d = '0;
                cnt_d   = 8'd0;
                if (skip) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    mem_en    = 1'b1;
                    mem_we    = we_q;
                    mem_wstrb = lane_mask(f3_q, off);
                    mem_addr  = {addr_q[XLEN-1:2], 2'b00};
                    mem_wdata = wdata_rep;
                    err_d     = 1'b0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                // ack wins over a simultaneous timeout
                if (mem_ack) begin
                    rdata_d = we_q ? '0 : ext_data;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_d == TO) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_rdata = rdata_q;
                rsp_err   = err_q;
                state_d   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (state_q == S_IDLE && req_valid) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

endmodule
